// File: rtl/xbus_arb2.sv
// Two-master round-robin arbiter for the shared memory/peripheral bus.
// Writes pass straight through; a read holds the bus until its response or a timeout.
module xbus_arb2 #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       RESP_TIMEOUT = 255,
    parameter logic [DATA_W-1:0] ERR_DATA     = 32'hDEADBEEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // master 0 (CPU data)
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_ack_o,
    output logic                m0_resp_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    // master 1 (UART debug/loader)
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_ack_o,
    output logic                m1_resp_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    // shared slave bus
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W/8-1:0] s_be_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_ack_i,
    input  logic                s_resp_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    output logic                err_o,
    // observation of registered arbiter state
    output logic                dbg_state_o,
    output logic                dbg_rr_ptr_o
);

    localparam int unsigned CNT_W = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } state_e;

    // Handshake: a request transfers in the cycle where req and ack are both high;
    // every accepted read is answered by exactly one resp pulse in a later cycle.
    state_e             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic               owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               gnt;
    logic               any_req;
    logic               resp_hit;
    logic [DATA_W-1:0]  resp_data;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        resp_hit  = 1'b0;
        resp_data = '0;

        m0_ack_o   = 1'b0;
        m1_ack_o   = 1'b0;
        m0_resp_o  = 1'b0;
        m1_resp_o  = 1'b0;
        m0_rdata_o = '0;
        m1_rdata_o = '0;
        err_o      = 1'b0;
        s_req_o    = 1'b0;

        any_req = m0_req_i | m1_req_i;
        gnt     = (m0_req_i & m1_req_i) ? rr_ptr_q : m1_req_i;

        // With no requester gnt is 0, so the idle bus carries master 0's bundle.
        s_we_o    = gnt ? m1_we_i    : m0_we_i;
        s_addr_o  = gnt ? m1_addr_i  : m0_addr_i;
        s_be_o    = gnt ? m1_be_i    : m0_be_i;
        s_wdata_o = gnt ? m1_wdata_i : m0_wdata_i;

        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    s_req_o = any_req;
                    if (any_req && s_ack_i) begin
                        m0_ack_o = ~gnt;
                        m1_ack_o = gnt;
                        rr_ptr_d = ~gnt;
                        if (!s_we_o) begin
                            owner_d = gnt;
                            cnt_d   = CNT_W'(1);
                            state_d = WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    // A real response in the timeout cycle takes priority over the error.
                    if (s_resp_i) begin
                        resp_hit  = 1'b1;
                        resp_data = s_rdata_i;
                        state_d   = IDLE;
                    end else if (cnt_q == CNT_W'(RESP_TIMEOUT)) begin
                        resp_hit  = 1'b1;
                        resp_data = ERR_DATA;
                        err_o     = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (resp_hit) begin
            if (owner_q) begin
                m1_resp_o  = 1'b1;
                m1_rdata_o = resp_data;
            end else begin
                m0_resp_o  = 1'b1;
                m0_rdata_o = resp_data;
            end
        end

        dbg_state_o  = (state_q == WAIT_RESP);
        dbg_rr_ptr_o = rr_ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/xbus_arb2.md
# xbus_arb2

Two-master round-robin arbiter that shares the sigma SoC's single memory/peripheral bus port between the CPU data master (master 0) and the UART debug/loader master (master 1). It sits between the two masters and the shared slave bus. Writes pass through with zero added latency. A read locks the bus until its response returns or a response timeout fires, so each read response is routed back to the master that issued it.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8)
- RESP_TIMEOUT, 255, cycles after read acceptance before an error response is generated (1..65535)
- ERR_DATA, 32'hDEADBEEF, rdata returned on timeout

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- m0_req_i / m1_req_i  in  1  master request; held until ack
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read
- m0_addr_i / m1_addr_i  in  ADDR_W  address
- m0_be_i / m1_be_i  in  DATA_W/8  byte enables
- m0_wdata_i / m1_wdata_i  in  DATA_W  write data
- m0_ack_o / m1_ack_o  out  1  request accepted (one cycle)
- m0_resp_o / m1_resp_o  out  1  read data valid (one cycle)
- m0_rdata_o / m1_rdata_o  out  DATA_W  read data; 0 when the matching resp is low
- s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o  out  slave request bundle
- s_ack_i  in  1  slave accepted request
- s_resp_i  in  1  slave read data valid
- s_rdata_i  in  DATA_W  slave read data
- err_o  out  1  one-cycle pulse when a timeout response is generated

## Operation
- Bus protocol: a transfer completes when req and ack are both high in the same cycle. Each accepted read produces exactly one resp pulse later.
- FSM states are IDLE and WAIT_RESP. Reset enters IDLE, sets rr_ptr = 0 (master 0 preferred) and clears the timeout counter.
- IDLE:
  - Grant is combinational. If only one master requests, it is granted. If both request, the master selected by rr_ptr is granted.
  - The granted master's bundle drives s_*. s_req_o = granted req.
  - s_ack_i is routed to the granted master's ack. The other master's ack is 0.
  - On an accepted write: stay in IDLE; rr_ptr becomes the other master.
  - On an accepted read: record owner = granted master, go to WAIT_RESP, and set rr_ptr to the other master.
  - A stray s_resp_i while in IDLE is ignored; nothing is routed.
- WAIT_RESP:
  - s_req_o = 0 and both master acks are 0.
  - When s_resp_i = 1, route resp and s_rdata_i to the owner, then return to IDLE.
  - The counter increments each cycle without s_resp_i. When it reaches RESP_TIMEOUT, assert owner resp with rdata = ERR_DATA and pulse err_o, then return to IDLE.
  - A slave response arriving after a timeout lands in IDLE and is dropped.
- Simultaneous events:
  - s_resp_i in the same cycle the counter reaches RESP_TIMEOUT: the real response wins; no err_o.
  - rst_i during WAIT_RESP: the pending read is abandoned with no resp. All outputs drop to their reset values on the next edge.
- When no request is active, the s_* data/address/we/be outputs carry master 0's bundle (a don't-care for the slave, but deterministic).

## Timing
- Reset values: s_req_o = 0, all acks = 0, all resps = 0, all rdata = 0, err_o = 0, FSM state = IDLE, rr_ptr = 0.
- Ack latency equals the slave's: ack is combinational from s_ack_i, so the arbiter adds 0 cycles.
- Read response is combinational from s_resp_i in WAIT_RESP, so the arbiter adds 0 cycles.
- The earliest next grant is the cycle after a read response. Back-to-back writes can complete every cycle.
- Timeout: acceptance happens at cycle T. With no slave response, the error resp and err_o are high in cycle T + RESP_TIMEOUT and IDLE resumes at T + RESP_TIMEOUT + 1.
- Registered state is FSM state, rr_ptr, owner, and the timeout counter (clog2(RESP_TIMEOUT + 1) bits). All are updated only on clk_i rising edges.

## Test plan
- Reset: hold rst_i for 3 cycles with both masters requesting -> s_req_o = 0, acks = 0 and err_o = 0 during reset. The first grant after reset goes to m0.
- Contention on writes: both masters write continuously with s_ack_i tied to 1 -> grants alternate m0, m1, m0, m1, …; each master gets one ack every 2 cycles, and no resp pulses occur.
- Read locking: m1 reads 0x100 while m0 requests a write; the slave returns 0x12345678 three cycles later -> m1_resp_o = 1 with m1_rdata_o = 0x12345678 and m0_rdata_o = 0. m0 is not acked until the cycle after that response.
- Timeout: RESP_TIMEOUT = 4; m0 reads with the slave never responding -> four cycles after acceptance, m0_resp_o = 1 with rdata = 0xDEADBEEF and err_o pulses once. A late s_resp_i arriving after that is ignored.
- Simultaneous resp and timeout: s_resp_i arrives exactly at cycle T + RESP_TIMEOUT with data 0xA5A5A5A5 -> owner receives 0xA5A5A5A5 and err_o stays 0.
- Reset mid-read: assert rst_i while in WAIT_RESP -> no resp is delivered, the FSM is in IDLE and rr_ptr = 0 after reset, and a subsequent m1-only read is granted immediately.
